// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between instruction fetch (port 0) and data (port 1).
// Round-robin tie-break by default; define MEM_ARB_DATA_PRIO_EN for fixed data-port priority.
module mem_port_arbiter #(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req0,
  input  logic          req1,
  input  logic [AW-1:0] addr0,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata0,
  input  logic [DW-1:0] wdata1,
  input  logic          we0,
  input  logic          we1,
  output logic          done0,
  output logic          done1,
  output logic [DW-1:0] rdata,
  output logic          mem_req,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic          mem_we,
  input  logic          mem_ready,
  input  logic [DW-1:0] mem_rdata,
  output logic          sel
);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t state;
  state_t state_next;
  logic   any_req;
  logic   winner;
  logic   start;
  logic   finish;

  assign any_req = req0 | req1;
  assign start   = (state == IDLE) & any_req;
  assign finish  = (state == BUSY) & mem_ready;

  // NOTE: sequential state is updated with non-blocking assignments only, so every
  // register samples the pre-edge value of every other register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // NOTE: every combinational output gets a default first, so no path can infer a latch.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (any_req) state_next = BUSY;
      BUSY:    if (mem_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    mem_req   = (state == BUSY);
    mem_addr  = sel ? addr1 : addr0;
    mem_wdata = sel ? wdata1 : wdata0;
    mem_we    = mem_req & (sel ? we1 : we0);
  end

`ifdef MEM_ARB_DATA_PRIO_EN
  // Data port wins every tie; instruction fetch may starve under continuous data traffic.
  always_comb begin
    winner = 1'b1;
    if (req0 && !req1) winner = 1'b0;
  end
`else
  logic last_gnt;

  // Reset to 1 so that port 0 wins the first tie.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_gnt <= 1'b1;
    end else if (finish) begin
      last_gnt <= sel;
    end
  end

  always_comb begin
    winner = ~last_gnt;
    if (req0 && !req1) winner = 1'b0;
    else if (req1 && !req0) winner = 1'b1;
  end
`endif

  // sel is latched only when a transaction starts and otherwise holds, also through IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel   <= 1'b0;
      done0 <= 1'b0;
      done1 <= 1'b0;
      rdata <= '0;
    end else begin
      done0 <= 1'b0;
      done1 <= 1'b0;
      if (start) begin
        sel <= winner;
      end
      if (finish) begin
        rdata <= mem_rdata;
        done0 <= ~sel;
        done1 <= sel;
      end
    end
  end

endmodule
